// File: rtl/bcd_to_bin_seq.sv
// ============================================================================
// Module  : bcd_to_bin_seq
// Brief   : Sequential BCD-to-binary converter (Horner, one digit per clock)
//           with valid/ready handshakes, overflow and invalid-digit flags.
//           Optional macro BCD_DIGIT_CHECK_EN enables digit (>9) checking.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_to_bin_seq #(
  parameter  int DIGITS = 5,
  parameter  int BIN_W  = 32,
  localparam int CNT_W  = $clog2(DIGITS) + 1
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [4*DIGITS-1:0] BCD,
  input  logic                IN_VALID,
  output logic                IN_READY,
  output logic [BIN_W-1:0]    BIN,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic                OVF,
  output logic                ERR
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [4*DIGITS-1:0] r_sreg;
  logic [BIN_W-1:0]    r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ovf;
  logic [BIN_W-1:0]    r_bin;
  logic                r_ovf_out;

  logic [3:0]          w_digit;
  logic [BIN_W+3:0]    w_acc_ext;
  logic [BIN_W+3:0]    w_mac;
  logic                w_mac_ovf;
  logic                w_last;
  logic                w_err_all;
  logic [BIN_W-1:0]    w_bin_fin;
  logic                w_ovf_fin;

  // acc*10 + digit evaluated 4 bits wide of the result so truncation is visible
  assign w_digit   = r_sreg[4*DIGITS-1 -: 4];
  assign w_acc_ext = {4'b0000, r_acc};
  assign w_mac     = (w_acc_ext << 3) + (w_acc_ext << 1) + {{BIN_W{1'b0}}, w_digit};
  assign w_mac_ovf = |w_mac[BIN_W+3:BIN_W];
  assign w_last    = (r_state == S_CONV) && (r_cnt == '0);

  assign w_bin_fin = w_err_all ? '0 : w_mac[BIN_W-1:0];
  assign w_ovf_fin = !w_err_all && (r_ovf || w_mac_ovf);

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    IN_READY    = 1'b0;
    OUT_VALID   = 1'b0;
    case (r_state)
      S_IDLE: begin
        IN_READY = !RESET;
        if (IN_VALID) w_state_nxt = S_CONV;
      end
      S_CONV: begin
        if (r_cnt == '0) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        OUT_VALID = 1'b1;
        if (OUT_READY) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sreg    <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_bin     <= '0;
      r_ovf_out <= 1'b0;
    end else begin
      if (r_state == S_IDLE && IN_VALID) begin
        r_sreg <= BCD;
        r_acc  <= '0;
        r_cnt  <= CNT_W'(DIGITS - 1);
        r_ovf  <= 1'b0;
      end else if (r_state == S_CONV) begin
        r_sreg <= r_sreg << 4;
        r_acc  <= w_mac[BIN_W-1:0];
        r_cnt  <= r_cnt - 1'b1;
        r_ovf  <= r_ovf | w_mac_ovf;
      end
      if (w_last) begin
        r_bin     <= w_bin_fin;
        r_ovf_out <= w_ovf_fin;
      end
    end
  end

`ifdef BCD_DIGIT_CHECK_EN
  logic r_err;
  logic r_err_out;

  assign w_err_all = r_err || (w_digit > 4'd9);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_err     <= 1'b0;
      r_err_out <= 1'b0;
    end else begin
      if (r_state == S_IDLE && IN_VALID) r_err <= 1'b0;
      else if (r_state == S_CONV)        r_err <= w_err_all;
      if (w_last) r_err_out <= w_err_all;
    end
  end

  assign ERR = r_err_out;
`else
  assign w_err_all = 1'b0;
  assign ERR       = 1'b0;
`endif

  assign BIN = r_bin;
  assign OVF = r_ovf_out;

endmodule

`default_nettype wire

// File: tb/tb_bcd_to_bin_seq.sv
// ============================================================================
// Module  : tb_bcd_to_bin_seq
// Brief   : Directed self-checking bench for bcd_to_bin_seq (32- and 16-bit).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_to_bin_seq;

  logic        clk;
  logic        rst;
  logic [19:0] bcd;
  logic        in_valid;
  logic        out_ready;

  logic        ird32, oval32, ovf32, err32;
  logic [31:0] bin32;
  logic        ird16, oval16, ovf16, err16;
  logic [15:0] bin16;

  int checks = 0;
  int errors = 0;

  bcd_to_bin_seq #(.DIGITS(5), .BIN_W(32)) u_dut32 (
    .CLK(clk), .RESET(rst), .BCD(bcd), .IN_VALID(in_valid), .IN_READY(ird32),
    .BIN(bin32), .OUT_VALID(oval32), .OUT_READY(out_ready), .OVF(ovf32), .ERR(err32)
  );

  bcd_to_bin_seq #(.DIGITS(5), .BIN_W(16)) u_dut16 (
    .CLK(clk), .RESET(rst), .BCD(bcd), .IN_VALID(in_valid), .IN_READY(ird16),
    .BIN(bin16), .OUT_VALID(oval16), .OUT_READY(out_ready), .OVF(ovf16), .ERR(err16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus only: offer a word, then return cycles from accept edge to OUT_VALID (-1 on timeout).
  task automatic run_word(input logic [19:0] b, output int lat);
    lat      = -1;
    bcd      = b;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !ird32; i++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (oval32) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; bcd = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ird32 !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b exp 0", ird32); end
    checks++; if (oval32 !== 1'b0 || oval16 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b/%0b exp 0", oval32, oval16); end
    checks++; if (bin32 !== 32'd0 || ovf32 !== 1'b0 || err32 !== 1'b0) begin errors++; $display("FAIL reset_outputs got bin %0h ovf %0b err %0b exp 0", bin32, ovf32, err32); end
    rst = 1'b0;
    #1;
    checks++; if (ird32 !== 1'b1 || ird16 !== 1'b1) begin errors++; $display("FAIL idle_in_ready got %0b/%0b exp 1", ird32, ird16); end
  endtask

  task automatic test_basic();
    int lat;
    run_word(20'h12345, lat);
    checks++; if (lat != 5) begin errors++; $display("FAIL basic_latency got %0d exp 5", lat); end
    checks++; if (bin32 !== 32'h3039) begin errors++; $display("FAIL basic_bin got %0h exp 3039", bin32); end
    checks++; if (ovf32 !== 1'b0 || err32 !== 1'b0) begin errors++; $display("FAIL basic_flags got ovf %0b err %0b exp 0 0", ovf32, err32); end
    checks++; if (ird32 !== 1'b0) begin errors++; $display("FAIL basic_ready_in_done got %0b exp 0", ird32); end
    release_out();
    checks++; if (oval32 !== 1'b0 || ird32 !== 1'b1) begin errors++; $display("FAIL basic_release got oval %0b ird %0b exp 0 1", oval32, ird32); end
    checks++; if (bin32 !== 32'h3039) begin errors++; $display("FAIL basic_hold got %0h exp 3039", bin32); end
  endtask

  task automatic test_back_to_back();
    int acc_cyc[2];
    logic [31:0] res[2];
    int na = 0, nr = 0, rdy_cnt = 0, bad = 0;
    acc_cyc[0] = 0; acc_cyc[1] = 0; res[0] = 'x; res[1] = 'x;
    bcd = 20'h99999; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 40 && nr < 2; c++) begin
      if (oval32) begin
        res[nr] = bin32;
        nr++;
      end
      if (ird32 && oval32) bad++;
      if (na == 1 && ird32) rdy_cnt++;
      if (ird32 && in_valid && na < 2) begin
        acc_cyc[na] = c;
        na++;
      end
      @(posedge clk); #1;
      if (na == 1) bcd = 20'h00000;
      if (na == 2) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    checks++; if (nr != 2) begin errors++; $display("FAIL b2b_results got %0d exp 2", nr); end
    checks++; if (res[0] !== 32'h1869F) begin errors++; $display("FAIL b2b_first got %0h exp 1869f", res[0]); end
    checks++; if (res[1] !== 32'h0) begin errors++; $display("FAIL b2b_second got %0h exp 0", res[1]); end
    checks++; if (acc_cyc[1] - acc_cyc[0] != 7) begin errors++; $display("FAIL b2b_gap got %0d exp 7", acc_cyc[1] - acc_cyc[0]); end
    checks++; if (rdy_cnt != 1 || bad != 0) begin errors++; $display("FAIL b2b_in_ready got rdy %0d overlap %0d exp 1 0", rdy_cnt, bad); end
  endtask

  task automatic test_backpressure();
    int lat;
    int unstable = 0;
    run_word(20'h00777, lat);
    checks++; if (lat != 5 || bin32 !== 32'd777) begin errors++; $display("FAIL bp_first got lat %0d bin %0d exp 5 777", lat, bin32); end
    for (int i = 0; i < 10; i++) begin
      bcd = 20'($urandom_range(0, 20'h99999)); in_valid = 1'b1;
      @(posedge clk); #1;
      if (bin32 !== 32'd777 || ovf32 !== 1'b0 || err32 !== 1'b0 || oval32 !== 1'b1 || ird32 !== 1'b0) unstable++;
    end
    checks++; if (unstable != 0) begin errors++; $display("FAIL bp_stable got %0d bad cycles exp 0", unstable); end
    bcd = 20'h00321; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (oval32 !== 1'b0 || ird32 !== 1'b1 || bin32 !== 32'd777) begin errors++; $display("FAIL bp_release got oval %0b ird %0b bin %0d exp 0 1 777", oval32, ird32, bin32); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (ird32 !== 1'b0) begin errors++; $display("FAIL bp_accept got ird %0b exp 0", ird32); end
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (oval32) begin lat = k; break; end
    end
    checks++; if (lat != 5 || bin32 !== 32'd321) begin errors++; $display("FAIL bp_second got lat %0d bin %0d exp 5 321", lat, bin32); end
    release_out();
  endtask

  task automatic test_reset_mid();
    int rose = 0;
    bcd = 20'h54321; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++; if (bin32 !== 32'd0 || ird32 !== 1'b1) begin errors++; $display("FAIL rstmid_state got bin %0d ird %0b exp 0 1", bin32, ird32); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (oval32) rose++;
    end
    checks++; if (rose != 0) begin errors++; $display("FAIL rstmid_no_valid got %0d exp 0", rose); end
    begin
      int lat;
      run_word(20'h00042, lat);
      checks++; if (lat != 5 || bin32 !== 32'd42) begin errors++; $display("FAIL rstmid_next got lat %0d bin %0d exp 5 42", lat, bin32); end
      release_out();
    end
  endtask

  task automatic test_ovf16();
    logic [19:0] vin [3];
    logic [15:0] vbin[3];
    logic        vovf[3];
    int lat;
    vin[0] = 20'h65535; vbin[0] = 16'hFFFF; vovf[0] = 1'b0;
    vin[1] = 20'h65536; vbin[1] = 16'h0000; vovf[1] = 1'b1;
    vin[2] = 20'h99999; vbin[2] = 16'h869F; vovf[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_word(vin[i], lat);
      checks++;
      if (lat != 5 || oval16 !== 1'b1 || bin16 !== vbin[i] || ovf16 !== vovf[i])
        begin errors++; $display("FAIL ovf16_%0d got lat %0d bin %0h ovf %0b exp 5 %0h %0b", i, lat, bin16, ovf16, vbin[i], vovf[i]); end
      if (i == 1) begin
        checks++; if (bin32 !== 32'd65536 || ovf32 !== 1'b0) begin errors++; $display("FAIL ovf32_wide got bin %0d ovf %0b exp 65536 0", bin32, ovf32); end
      end
      release_out();
    end
  endtask

  task automatic test_invalid();
    int lat;
    run_word(20'h1A345, lat);
    checks++; if (lat != 5) begin errors++; $display("FAIL inv_latency got %0d exp 5", lat); end
`ifdef BCD_DIGIT_CHECK_EN
    checks++; if (err32 !== 1'b1 || bin32 !== 32'd0 || ovf32 !== 1'b0) begin errors++; $display("FAIL inv_check got err %0b bin %0d ovf %0b exp 1 0 0", err32, bin32, ovf32); end
`else
    checks++; if (err32 !== 1'b0 || bin32 !== 32'd20345 || ovf32 !== 1'b0) begin errors++; $display("FAIL inv_raw got err %0b bin %0d ovf %0b exp 0 20345 0", err32, bin32, ovf32); end
`endif
    release_out();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_ovf16();
    test_invalid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
